// File: rtl/esm_pkg.sv
// esm_pkg: shared defaults, slot-index width helper and FSM encoding for the candidate list block
package esm_pkg;
  localparam int BS_DEF = 16;
  localparam int THRESH_DEF = 4;
  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH, WAIT_SEL} state_t;
  function automatic int bsb_f(input int bs);
    return (bs > 1) ? $clog2(bs) : 1;
  endfunction
endpackage

// File: rtl/popcount_bs.sv
// popcount_bs: combinational population count of a BS-bit bitmap
module popcount_bs
  import esm_pkg::*;
#(
  parameter int BS = BS_DEF,
  localparam int BSB = bsb_f(BS)
) (
  input  logic [BS-1:0] bits_i,
  output logic [BSB:0]  count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < BS; i++) count_o = count_o + (BSB+1)'(bits_i[i]);
  end
endmodule

// File: rtl/cand_list_gen.sv
// cand_list_gen: tracks a live bitmap of candidate slots and publishes registered snapshots
module cand_list_gen
  import esm_pkg::*;
#(
  parameter int BS = BS_DEF,
  parameter int THRESH = THRESH_DEF,
  localparam int BSB = bsb_f(BS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set_valid,
  input  logic [BSB-1:0] set_index,
  input  logic           sel_valid,
  input  logic [BSB-1:0] sel_index,
  input  logic           flush,
  input  logic           cand_ready,
  output logic           cand_valid,
  output logic [BS-1:0]  cand_list,
  output logic [BSB:0]   cand_count,
  output logic           empty,
  output logic           full,
  output logic           err
);
  state_t state_q, state_d;
  logic [BS-1:0] live_q, live_d, live_clr, clr_mask, set_mask, list_q, list_d;
  logic [BSB:0] cnt_d, cnt_q;
  logic empty_q, full_q, err_q, set_bad, clr_bad, clr_ok, pub;
  popcount_bs #(.BS(BS)) u_pop (.bits_i(live_d), .count_o(cnt_d));
  // Clear is applied before set, so a set may legally re-mark a bit cleared this cycle
  always_comb begin
    clr_bad = sel_valid && (int'(sel_index) >= BS || !live_q[sel_index]);
    clr_ok = sel_valid && !clr_bad;
    clr_mask = clr_ok ? BS'(1) << sel_index : '0;
    live_clr = live_q & ~clr_mask;
    set_bad = set_valid && (int'(set_index) >= BS || live_clr[set_index]);
    set_mask = (set_valid && !set_bad) ? BS'(1) << set_index : '0;
    live_d = live_clr | set_mask;
    pub = int'(cnt_d) >= THRESH || (flush && |live_d);
  end
  always_comb begin
    state_d = state_q;
    list_d = list_q;
    case (state_q)
      IDLE:     state_d = |live_d ? COLLECT : IDLE;
      COLLECT: begin
        state_d = pub ? PUBLISH : (|live_d ? COLLECT : IDLE);
        list_d = pub ? live_d : list_q;
      end
      PUBLISH:  state_d = cand_ready ? WAIT_SEL : PUBLISH;
      WAIT_SEL: state_d = clr_ok ? (|live_d ? COLLECT : IDLE) : WAIT_SEL;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      live_q <= '0;
      list_q <= '0;
      cnt_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= live_d;
      list_q <= list_d;
      cnt_q <= cnt_d;
      empty_q <= ~|live_d;
      full_q <= &live_d;
      err_q <= set_bad | clr_bad;
    end
  end
  assign cand_valid = state_q == PUBLISH;
  assign cand_list = list_q;
  assign cand_count = cnt_q;
  assign empty = empty_q;
  assign full = full_q;
  assign err = err_q;
endmodule

// File: tb/tb_cand_list_gen.sv
// tb_cand_list_gen: directed vector table plus hand sequences for flush and reset corners
module tb_cand_list_gen;
  logic clk = 0, rst = 1;
  logic set_valid = 0, sel_valid = 0, flush = 0, cand_ready = 0;
  logic [3:0] set_index = 0, sel_index = 0;
  logic cand_valid, empty, full, err;
  logic [15:0] cand_list;
  logic [4:0] cand_count;
  int total = 0, bad = 0;
  typedef struct {
    int sv, si, cl, ci, fl, rd, cv, lst, cnt, emp, ful, er;
  } vec_t;
  vec_t vt[19];
  cand_list_gen #(.BS(16), .THRESH(4)) dut (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_index(set_index),
    .sel_valid(sel_valid), .sel_index(sel_index), .flush(flush), .cand_ready(cand_ready),
    .cand_valid(cand_valid), .cand_list(cand_list), .cand_count(cand_count),
    .empty(empty), .full(full), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int cv, input int lst, input int cnt, input int emp, input int ful, input int er);
    chk({tag, " cand_valid"}, int'(cand_valid), cv);
    chk({tag, " cand_list"}, int'(cand_list), lst);
    chk({tag, " cand_count"}, int'(cand_count), cnt);
    chk({tag, " empty"}, int'(empty), emp);
    chk({tag, " full"}, int'(full), ful);
    chk({tag, " err"}, int'(err), er);
  endtask
  task automatic apply(input int sv, input int si, input int cl, input int ci, input int fl, input int rd);
    set_valid = 1'(sv);
    set_index = 4'(si);
    sel_valid = 1'(cl);
    sel_index = 4'(ci);
    flush = 1'(fl);
    cand_ready = 1'(rd);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    set_valid = 0; sel_valid = 0; flush = 0; cand_ready = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    //        sv si cl ci fl rd   cv  list    cnt emp ful err
    vt[0]  = '{1, 3, 0, 0, 0, 0,  0, 'h0000, 1, 0, 0, 0};
    vt[1]  = '{1, 7, 0, 0, 0, 0,  0, 'h0000, 2, 0, 0, 0};
    vt[2]  = '{1, 9, 0, 0, 0, 0,  0, 'h0000, 3, 0, 0, 0};
    vt[3]  = '{1,12, 0, 0, 0, 0,  1, 'h1288, 4, 0, 0, 0};
    vt[4]  = '{1, 1, 0, 0, 0, 0,  1, 'h1288, 5, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 0,  1, 'h1288, 5, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 0,  1, 'h1288, 5, 0, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 0,  1, 'h1288, 5, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0,  1, 'h1288, 5, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 1,  0, 'h1288, 5, 0, 0, 0};
    vt[10] = '{0, 0, 1, 7, 0, 0,  0, 'h1288, 4, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0,  1, 'h120A, 4, 0, 0, 0};
    vt[12] = '{1, 5, 0, 0, 0, 1,  0, 'h120A, 5, 0, 0, 0};
    vt[13] = '{1, 5, 0, 0, 0, 0,  0, 'h120A, 5, 0, 0, 1};
    vt[14] = '{0, 0, 1, 0, 0, 0,  0, 'h120A, 5, 0, 0, 1};
    vt[15] = '{1, 5, 1, 5, 0, 0,  0, 'h120A, 5, 0, 0, 0};
    vt[16] = '{0, 0, 0, 0, 0, 0,  1, 'h122A, 5, 0, 0, 0};
    vt[17] = '{0, 0, 1, 1, 0, 0,  1, 'h122A, 4, 0, 0, 0};
    vt[18] = '{0, 0, 0, 0, 0, 1,  0, 'h122A, 4, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 1, 0, 0);
    #2 rst = 0;
    foreach (vt[k]) begin
      apply(vt[k].sv, vt[k].si, vt[k].cl, vt[k].ci, vt[k].fl, vt[k].rd);
      chk_all($sformatf("vec%0d", k), vt[k].cv, vt[k].lst, vt[k].cnt, vt[k].emp, vt[k].ful, vt[k].er);
    end
    do_reset();
    apply(0, 0, 0, 0, 1, 0);
    chk_all("flush_empty", 0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("flush_empty_later cand_valid", int'(cand_valid), 0);
    apply(1, 2, 0, 0, 0, 0);
    chk_all("set2", 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    chk_all("flush_pub", 1, 'h0004, 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) apply(1, i, 0, 0, 0, 0);
    chk_all("all_set", 1, 'h000F, 16, 0, 1, 0);
    rst = 1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1, 0, 0);
    set_valid = 0;
    #2 rst = 0;
    apply(1, 3, 0, 0, 0, 0);
    chk_all("post_rst", 0, 0, 1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
